// File: rtl/vend_pkg.sv
// Shared constants and types for the coin change dispenser.
// Denomination index order is 4..0 = 100, 25, 10, 5, 1 cents.
package vend_pkg;

    localparam int NUM_DENOM = 5;

    localparam int IDX_100 = 4;
    localparam int IDX_25  = 3;
    localparam int IDX_10  = 2;
    localparam int IDX_5   = 1;
    localparam int IDX_1   = 0;

    localparam logic [15:0] DENOM_100 = 16'd100;
    localparam logic [15:0] DENOM_25  = 16'd25;
    localparam logic [15:0] DENOM_10  = 16'd10;
    localparam logic [15:0] DENOM_5   = 16'd5;
    localparam logic [15:0] DENOM_1   = 16'd1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_EJECT,
        ST_WAIT_ACK,
        ST_DONE,
        ST_FAULT
    } state_t;

    function automatic logic [15:0] denom_val(input int idx);
        case (idx)
            IDX_100: denom_val = DENOM_100;
            IDX_25:  denom_val = DENOM_25;
            IDX_10:  denom_val = DENOM_10;
            IDX_5:   denom_val = DENOM_5;
            default: denom_val = DENOM_1;
        endcase
    endfunction

endpackage

// File: rtl/vend_denom_select.sv
// Combinational greedy picker: largest stocked, unjammed coin
// that still fits the remainder.
module vend_denom_select
    import vend_pkg::*;
(
    input  logic [15:0]          remain,
    input  logic [NUM_DENOM-1:0] empty,
    input  logic [NUM_DENOM-1:0] jam,
    output logic [NUM_DENOM-1:0] onehot,
    output logic [15:0]          value,
    output logic                 found
);

    logic [NUM_DENOM-1:0] usable;

    always_comb begin
        usable = '0;
        for (int i = 0; i < NUM_DENOM; i++) begin
            usable[i] = !empty[i] && !jam[i] && (denom_val(i) <= remain);
        end
    end

    always_comb begin
        onehot = '0;
        value  = '0;
        found  = 1'b0;
        for (int i = NUM_DENOM - 1; i >= 0; i--) begin
            if (!found && usable[i]) begin
                onehot[i] = 1'b1;
                value     = denom_val(i);
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vend_change_dispenser.sv
// Change payout sequencer: one coin per eject/ack round trip,
// skipping empty or jammed hoppers, ending in DONE or FAULT.
module vend_change_dispenser
    import vend_pkg::*;
#(
    parameter int PULSE_CYCLES = 4,
    parameter int ACK_TIMEOUT  = 255
)
(
    input  logic                 I_CLK,
    input  logic                 I_RESET,
    input  logic                 I_REQ_VALID,
    input  logic [15:0]          I_REQ_AMOUNT,
    output logic                 O_REQ_READY,
    input  logic [NUM_DENOM-1:0] I_HOPPER_EMPTY,
    output logic [NUM_DENOM-1:0] O_EJECT,
    input  logic                 I_EJECT_ACK,
    output logic                 O_BUSY,
    output logic                 O_DONE,
    output logic                 O_FAULT,
    output logic [15:0]          O_REMAIN,
    output logic [7:0]           O_COINS
);

    localparam logic [15:0] PULSE_LAST   = 16'(PULSE_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(ACK_TIMEOUT - 1);

    state_t               state;
    logic [15:0]          remain;
    logic [15:0]          pulse_cnt;
    logic [15:0]          wait_cnt;
    logic [15:0]          sel_value;
    logic [NUM_DENOM-1:0] sel_onehot;
    logic [NUM_DENOM-1:0] jam;
    logic [7:0]           coins;

    logic [NUM_DENOM-1:0] pick_onehot;
    logic [15:0]          pick_value;
    logic                 pick_found;

    vend_denom_select u_select (
        .remain (remain),
        .empty  (I_HOPPER_EMPTY),
        .jam    (jam),
        .onehot (pick_onehot),
        .value  (pick_value),
        .found  (pick_found)
    );

    assign O_REMAIN = remain;
    assign O_COINS  = coins;

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state       <= ST_IDLE;
            remain      <= '0;
            pulse_cnt   <= '0;
            wait_cnt    <= '0;
            sel_value   <= '0;
            sel_onehot  <= '0;
            jam         <= '0;
            coins       <= '0;
            O_REQ_READY <= 1'b1;
            O_BUSY      <= 1'b0;
            O_EJECT     <= '0;
            O_DONE      <= 1'b0;
            O_FAULT     <= 1'b0;
        end else begin
            O_DONE  <= 1'b0;
            O_FAULT <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (I_REQ_VALID && O_REQ_READY) begin
                        remain      <= I_REQ_AMOUNT;
                        coins       <= '0;
                        jam         <= '0;
                        O_REQ_READY <= 1'b0;
                        O_BUSY      <= 1'b1;
                        state       <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    if (remain == '0) begin
                        O_DONE <= 1'b1;
                        state  <= ST_DONE;
                    end else if (pick_found) begin
                        sel_onehot <= pick_onehot;
                        sel_value  <= pick_value;
                        O_EJECT    <= pick_onehot;
                        pulse_cnt  <= '0;
                        state      <= ST_EJECT;
                    end else begin
                        O_FAULT <= 1'b1;
                        state   <= ST_FAULT;
                    end
                end
                ST_EJECT: begin
                    if (pulse_cnt == PULSE_LAST) begin
                        O_EJECT  <= '0;
                        wait_cnt <= '0;
                        state    <= ST_WAIT_ACK;
                    end else begin
                        pulse_cnt <= pulse_cnt + 16'd1;
                    end
                end
                ST_WAIT_ACK: begin
                    // ack takes priority over a timeout in the same cycle
                    if (I_EJECT_ACK) begin
                        remain <= remain - sel_value;
                        if (coins != 8'hFF) begin
                            coins <= coins + 8'd1;
                        end
                        state <= ST_SELECT;
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        jam   <= jam | sel_onehot;
                        state <= ST_SELECT;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                ST_DONE, ST_FAULT: begin
                    O_REQ_READY <= 1'b1;
                    O_BUSY      <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_change_dispenser.sv
// Directed bench for the change dispenser with a greedy
// payout model and a per-cycle output monitor.
module tb_vend_change_dispenser;

    localparam int PC = 4;
    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        I_RESET = 1'b1;
    logic        I_REQ_VALID = 1'b0;
    logic [15:0] I_REQ_AMOUNT = '0;
    logic        O_REQ_READY;
    logic [4:0]  I_HOPPER_EMPTY = '0;
    logic [4:0]  O_EJECT;
    logic        I_EJECT_ACK = 1'b0;
    logic        O_BUSY;
    logic        O_DONE;
    logic        O_FAULT;
    logic [15:0] O_REMAIN;
    logic [7:0]  O_COINS;

    always #5 clk = ~clk;

    vend_change_dispenser #(
        .PULSE_CYCLES (PC),
        .ACK_TIMEOUT  (TO)
    ) dut (
        .I_CLK          (clk),
        .I_RESET        (I_RESET),
        .I_REQ_VALID    (I_REQ_VALID),
        .I_REQ_AMOUNT   (I_REQ_AMOUNT),
        .O_REQ_READY    (O_REQ_READY),
        .I_HOPPER_EMPTY (I_HOPPER_EMPTY),
        .O_EJECT        (O_EJECT),
        .I_EJECT_ACK    (I_EJECT_ACK),
        .O_BUSY         (O_BUSY),
        .O_DONE         (O_DONE),
        .O_FAULT        (O_FAULT),
        .O_REMAIN       (O_REMAIN),
        .O_COINS        (O_COINS)
    );

    int checks = 0;
    int errors = 0;
    int edges = 0;

    always @(posedge clk) edges <= edges + 1;

    logic [4:0] exp_q[$];
    int         exp_remain = 0;
    int         exp_coins = 0;
    bit         exp_fault = 1'b0;
    bit         mon_en = 1'b0;
    int         outcomes = 0;
    int         last_fault = 0;
    int         acc_edge = 0;
    int         first_off = -1;
    bit         first_pending = 1'b0;
    int         ack_delay = 2;
    logic [4:0] dead = '0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Greedy payout with per-hopper empty and never-acking masks.
    function automatic void model(input int amt, input logic [4:0] empty,
                                  input logic [4:0] dd);
        int vals[5] = '{1, 5, 10, 25, 100};
        int rem;
        int coins;
        int pick;
        logic [4:0] jm;
        rem = amt;
        coins = 0;
        jm = '0;
        exp_q.delete();
        for (int step = 0; step < 2000; step++) begin
            pick = -1;
            if (rem == 0) break;
            for (int i = 4; i >= 0; i--) begin
                if (pick < 0 && vals[i] <= rem && !empty[i] && !jm[i]) pick = i;
            end
            if (pick < 0) break;
            exp_q.push_back(5'(1 << pick));
            if (dd[pick]) jm[pick] = 1'b1;
            else begin
                rem -= vals[pick];
                if (coins < 255) coins++;
            end
        end
        exp_remain = rem;
        exp_coins = coins;
        exp_fault = (rem != 0);
    endfunction

    // Output monitor.
    initial begin
        logic [4:0] prev;
        logic       prev_out;
        int         width;
        prev = '0;
        prev_out = 1'b0;
        width = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (O_EJECT != 0) begin
                    if (prev == 0) begin
                        if (first_pending) begin
                            first_off = edges - acc_edge;
                            first_pending = 1'b0;
                        end
                        if (exp_q.size() == 0) chk("eject_unexpected", O_EJECT, 0);
                        else chk("eject_denom", O_EJECT, exp_q.pop_front());
                        width = 1;
                    end else begin
                        width++;
                    end
                end else if (prev != 0) begin
                    chk("pulse_width", width, PC);
                end
                if (O_DONE || O_FAULT) begin
                    chk("out_one_cycle", prev_out, 0);
                    chk("out_fault", O_FAULT, exp_fault);
                    chk("out_done", O_DONE, !exp_fault);
                    chk("out_remain", O_REMAIN, exp_remain);
                    chk("out_coins", O_COINS, exp_coins);
                    chk("ejects_left", exp_q.size(), 0);
                    last_fault = O_FAULT;
                    outcomes++;
                end
            end
            prev = O_EJECT;
            prev_out = O_DONE || O_FAULT;
        end
    end

    // Hopper responder: ack a few cycles after each pulse ends.
    initial begin
        logic [4:0] prev;
        logic [4:0] cur;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = O_EJECT;
            if (prev != 0 && cur == 0 && (prev & dead) == 0) begin
                repeat (ack_delay) @(negedge clk);
                I_EJECT_ACK = 1'b1;
                @(negedge clk);
                I_EJECT_ACK = 1'b0;
                cur = O_EJECT;
            end
            prev = cur;
        end
    end

    task automatic do_req(input logic [15:0] amt, input bit keep_valid);
        int n;
        @(negedge clk);
        I_REQ_VALID = 1'b1;
        I_REQ_AMOUNT = amt;
        n = 0;
        while (!O_REQ_READY && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!O_REQ_READY) chk("req_ready_wait", 0, 1);
        @(negedge clk);
        acc_edge = edges;
        if (!keep_valid) I_REQ_VALID = 1'b0;
    endtask

    task automatic run_txn(input logic [15:0] amt, input logic [4:0] empty,
                           input logic [4:0] dd, input int lit_fault,
                           input int lit_remain, input int lit_coins);
        int start;
        int n;
        I_HOPPER_EMPTY = empty;
        dead = dd;
        model(amt, empty, dd);
        start = outcomes;
        first_off = -1;
        first_pending = 1'b1;
        mon_en = 1'b1;
        do_req(amt, 1'b0);
        n = 0;
        while (outcomes == start && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (outcomes == start) chk("outcome_timeout", 0, 1);
        @(negedge clk);
        chk("lit_fault", last_fault, lit_fault);
        chk("lit_remain", O_REMAIN, lit_remain);
        chk("lit_coins", O_COINS, lit_coins);
        chk("lit_ready", O_REQ_READY, 1);
        chk("lit_busy", O_BUSY, 0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        I_RESET = 1'b0;
        @(negedge clk);
        chk("rst_eject", O_EJECT, 0);
        chk("rst_done", O_DONE, 0);
        chk("rst_fault", O_FAULT, 0);
        chk("rst_busy", O_BUSY, 0);
        chk("rst_ready", O_REQ_READY, 1);
        chk("rst_remain", O_REMAIN, 0);
        chk("rst_coins", O_COINS, 0);

        run_txn(16'd165, 5'b00000, 5'b00000, 0, 0, 5);
        chk("first_eject_T2", first_off, 1);
        run_txn(16'd30, 5'b01000, 5'b00000, 0, 0, 3);
        run_txn(16'd7, 5'b00001, 5'b00000, 1, 2, 1);
        run_txn(16'd25, 5'b00000, 5'b01000, 0, 0, 3);

        ack_delay = TO - 1;
        run_txn(16'd5, 5'b00000, 5'b00000, 0, 0, 1);
        ack_delay = 2;

        // zero amount, with a second request held while busy
        I_HOPPER_EMPTY = '0;
        dead = '0;
        model(0, 5'b00000, 5'b00000);
        first_off = -1;
        first_pending = 1'b1;
        do_req(16'd0, 1'b1);
        I_REQ_AMOUNT = 16'd99;
        chk("zero_ready_T1", O_REQ_READY, 0);
        @(negedge clk);
        chk("zero_done_T2", O_DONE, 1);
        I_REQ_VALID = 1'b0;
        @(negedge clk);
        chk("zero_ready_T3", O_REQ_READY, 1);
        chk("zero_done_T3", O_DONE, 0);
        @(negedge clk);
        chk("zero_not_accepted", O_BUSY, 0);
        chk("zero_remain", O_REMAIN, 0);
        chk("zero_no_eject", first_off, -1);

        // reset in the middle of the first eject pulse
        mon_en = 1'b0;
        exp_q.delete();
        do_req(16'd200, 1'b0);
        n = 0;
        while (O_EJECT == 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_eject_seen", O_EJECT, 5'b10000);
        I_RESET = 1'b1;
        @(negedge clk);
        chk("rst_mid_eject", O_EJECT, 0);
        chk("rst_mid_ready", O_REQ_READY, 1);
        chk("rst_mid_remain", O_REMAIN, 0);
        chk("rst_mid_busy", O_BUSY, 0);
        I_RESET = 1'b0;
        repeat (6) @(negedge clk);
        chk("late_ack_busy", O_BUSY, 0);
        chk("late_ack_remain", O_REMAIN, 0);
        chk("late_ack_coins", O_COINS, 0);

        run_txn(16'd6, 5'b00000, 5'b00000, 0, 0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vend_change_dispenser.md
# vend_change_dispenser

Clocked controller that sequences the coin hoppers to pay out change after a vend transaction. It accepts a change amount in cents over a valid/ready handshake and ejects coins greedily, one at a time. The denominations are 100, 25, 10, 5 and 1. Empty or jammed hoppers are skipped, and the block reports done, or a fault with the unpaid remainder. It sits between the vending transaction FSM, which produces the change amount, and the five coin-hopper drivers.

## Interface
Parameters:
- PULSE_CYCLES, default 4: width of each eject pulse in clock cycles, minimum 1.
- ACK_TIMEOUT, default 255: number of WAIT_ACK cycles without an ack before the current hopper is declared jammed, minimum 1.

Ports:
- I_CLK  in  1: single clock. All logic is on the rising edge.
- I_RESET  in  1: reset, synchronous and active-high.
- I_REQ_VALID  in  1: change request valid.
- I_REQ_AMOUNT  in  16: change to pay, in cents.
- O_REQ_READY  out  1: high only in IDLE.
- I_HOPPER_EMPTY  in  5: bit4 = 100, bit3 = 25, bit2 = 10, bit1 = 5, bit0 = 1.
- O_EJECT  out  5: one-hot eject strobe, same bit order as I_HOPPER_EMPTY.
- I_EJECT_ACK  in  1: hopper confirms a coin dropped.
- O_BUSY  out  1: high in every state except IDLE.
- O_DONE  out  1: one-cycle pulse when the amount is fully paid.
- O_FAULT  out  1: one-cycle pulse when no usable denomination fits the remainder.
- O_REMAIN  out  16: amount still unpaid.
- O_COINS  out  8: coins ejected in the current or last transaction, saturating at 255.

## Operation
- States are IDLE, SELECT, EJECT, WAIT_ACK, DONE and FAULT.
- IDLE → SELECT:
  - Trigger: I_REQ_VALID && O_REQ_READY.
  - Capture: remain ← I_REQ_AMOUNT.
  - Clear: O_COINS ← 0, jam mask ← 0.
- A request with I_REQ_AMOUNT = 0 also passes through SELECT and reaches DONE.
- SELECT:
  - If remain == 0, go to DONE.
  - Otherwise pick the largest denomination d where d ≤ remain, !I_HOPPER_EMPTY[d] and !jam[d], then go to EJECT.
  - If no denomination qualifies, go to FAULT.
- EJECT: O_EJECT[d] is high for exactly PULSE_CYCLES cycles, then the FSM goes to WAIT_ACK. I_EJECT_ACK is ignored in EJECT.
- WAIT_ACK:
  - On I_EJECT_ACK: remain ← remain − d, O_COINS ← O_COINS + 1 (saturating), then go to SELECT.
  - If ACK_TIMEOUT cycles pass with no ack: jam[d] ← 1, remain is unchanged, then go to SELECT.
  - If the ack and the timeout fall in the same cycle, the ack wins.
- DONE: O_DONE = 1 for one cycle, then IDLE.
- FAULT: O_FAULT = 1 for one cycle, then IDLE. O_REMAIN holds the unpaid amount until the next request is accepted.
- Arithmetic:
  - Subtraction cannot underflow, because d ≤ remain is checked in SELECT.
  - Full 16-bit range is supported; 65535 takes 655 dollar coins plus 35 cents.
  - O_COINS saturates at 255, but dispensing continues past it.
- I_HOPPER_EMPTY is sampled only in SELECT. A hopper that empties during EJECT or WAIT_ACK is handled by the timeout.
- I_REQ_VALID while busy is not accepted. The requester must hold the request until it sees O_REQ_READY.

## Timing
- Reset values:
  - State = IDLE.
  - O_EJECT = 0, O_DONE = 0, O_FAULT = 0, O_BUSY = 0.
  - O_REQ_READY = 1.
  - O_REMAIN = 0, O_COINS = 0, jam mask = 0.
- All outputs are registered.
- Request accepted at edge T:
  - SELECT during cycle T+1.
  - O_EJECT is high in cycles T+2 through T+1+PULSE_CYCLES.
  - WAIT_ACK starts at T+2+PULSE_CYCLES.
- An ack sampled in WAIT_ACK cycle k gives SELECT, with remain updated, in cycle k+1.
- Cycles per coin = PULSE_CYCLES + ack latency + 1 (SELECT).
- A zero-amount request gives O_DONE in cycle T+2, and O_REQ_READY returns in cycle T+3.
- Reset mid-operation:
  - At the next edge, O_EJECT drops and the block enters the full reset state.
  - A coin in flight is not accounted for.
  - An I_EJECT_ACK arriving after reset is ignored.

## Structure
- Package vend_pkg holds:
  - The denomination constants (100, 25, 10, 5, 1) and the index order 4..0.
  - The state enum.
  - The NUM_DENOM = 5 constant.
- One sub-module, vend_denom_select: a combinational priority picker.
  - Inputs: remain, empty, jam.
  - Outputs: one-hot denomination, its value, and a found flag.
- The top level holds the FSM, the pulse counter, the timeout counter, the remainder and the coin counter.

## Test plan
- Request 165, all hoppers stocked, ack 2 cycles into each WAIT_ACK → ejects 100, 25, 25, 10, 5; O_DONE pulse; O_COINS = 5; O_REMAIN = 0.
- Request 30 with the 25 hopper empty → ejects 10, 10, 10; O_DONE; O_COINS = 3.
- Request 7 with the 1 hopper empty → ejects one 5, then O_FAULT pulse; O_REMAIN = 2; O_COINS = 1.
- Request 25, no ack on the quarter for ACK_TIMEOUT cycles → quarter jammed, then ejects 10, 10, 5; O_DONE; O_COINS = 3.
- Request 0 → O_DONE at T+2, O_EJECT never asserted. A second I_REQ_VALID at T+1 is not accepted, since O_REQ_READY = 0.
- Request 200, I_RESET asserted during the first EJECT → next cycle O_EJECT = 0, O_REQ_READY = 1, O_REMAIN = 0. A late ack is ignored.
